command_decoder_fifo: RTL and testbench

Parametrised successor to the GPU command decoder. It accepts pixel-write commands (column, row, pixel data, layer) from the paint/UI logic and buffers them in a small FIFO so that writes issued while VRAM is busy are not lost. It drains the FIFO to the VRAM write port whenever VRAM is available. It adds a hardware layer-clear mode that fills an entire layer with one pixel value. It sits between the command source and the multi-layer VRAM arbiter.

---
 rtl/command_decoder_fifo.sv | 141 ++++++++++++++
 tb/tb_command_decoder_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_decoder_fifo.sv
// Pixel-write command decoder: queues {row, column, pixel, layer} commands in a small FIFO,
// drains them to the VRAM write port, and can fill an entire layer with one pixel value.
module command_decoder_fifo #(
    parameter int COL_W  = 6,
    parameter int ROW_W  = 6,
    parameter int PX_W   = 8,
    parameter int LAYERS = 4,
    parameter int DEPTH  = 4,
    localparam int ADDR_W  = ROW_W + COL_W,
    localparam int LAYER_W = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_write,
    input  logic [PX_W-1:0]    in_px_data,
    input  logic [COL_W-1:0]   in_column,
    input  logic [ROW_W-1:0]   in_row,
    input  logic [LAYER_W-1:0] in_layer,
    input  logic               in_clear,
    input  logic               in_VRAM_available,
    output logic               out_write_available,
    output logic               out_write,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [PX_W-1:0]    out_px_data,
    output logic [LAYER_W-1:0] out_layer,
    output logic               out_busy,
    output logic               out_clear_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W+1)'(1);
    localparam logic [LAYER_W:0] LAYER_LIM = (LAYER_W+1)'(LAYERS);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
    state_t state;

    logic [ADDR_W-1:0]  fifo_addr  [DEPTH];
    logic [PX_W-1:0]    fifo_px    [DEPTH];
    logic [LAYER_W-1:0] fifo_layer [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic [ADDR_W-1:0]  clr_cnt;
    logic [PX_W-1:0]    clr_px;
    logic [LAYER_W-1:0] clr_layer;

    logic accept;
    logic push;
    logic pop;
    logic fifo_empty;

    // Commands aimed at a non-existent layer are accepted (handshake completes) but never stored.
    assign fifo_empty          = (count == '0);
    assign out_write_available = rst && (state == IDLE) && (count != FULL_CNT);
    assign accept              = in_write && out_write_available;
    assign push                = accept && ({1'b0, in_layer} < LAYER_LIM);
    assign pop                 = (state != CLEAR) && !fifo_empty && in_VRAM_available;
    assign out_busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= {in_row, in_column};
            fifo_px[wr_ptr]    <= in_px_data;
            fifo_layer[wr_ptr] <= in_layer;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            clr_cnt        <= '0;
            clr_px         <= '0;
            clr_layer      <= '0;
            out_write      <= 1'b0;
            out_addr       <= '0;
            out_px_data    <= '0;
            out_layer      <= '0;
            out_clear_done <= 1'b0;
        end else begin
            out_write      <= 1'b0;
            out_clear_done <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                out_write   <= 1'b1;
                out_addr    <= fifo_addr[rd_ptr];
                out_px_data <= fifo_px[rd_ptr];
                out_layer   <= fifo_layer[rd_ptr];
            end

            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (in_clear) begin
                        clr_layer <= in_layer;
                        clr_px    <= in_px_data;
                        clr_cnt   <= '0;
                        state     <= (accept || !fifo_empty) ? DRAIN : CLEAR;
                    end
                end
                DRAIN: begin
                    if (fifo_empty || (pop && count == ONE_CNT)) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    // A fill of a non-existent layer completes at once without touching VRAM.
                    if ({1'b0, clr_layer} >= LAYER_LIM) begin
                        out_clear_done <= 1'b1;
                        state          <= IDLE;
                    end else if (in_VRAM_available) begin
                        out_write   <= 1'b1;
                        out_addr    <= clr_cnt;
                        out_px_data <= clr_px;
                        out_layer   <= clr_layer;
                        clr_cnt     <= clr_cnt + ADDR_W'(1);
                        if (&clr_cnt) begin
                            out_clear_done <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_decoder_fifo.sv
// Self-checking bench for command_decoder_fifo: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_command_decoder_fifo;

    localparam int COL_W     = 6;
    localparam int ROW_W     = 6;
    localparam int PX_W      = 8;
    localparam int LAYERS    = 3;
    localparam int DEPTH     = 4;
    localparam int ADDR_W    = ROW_W + COL_W;
    localparam int LAYER_W   = 2;
    localparam int CLEAR_LEN = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [PX_W-1:0]    px;
        logic [LAYER_W-1:0] layer;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_write = 1'b0;
    logic [PX_W-1:0]    in_px_data = '0;
    logic [COL_W-1:0]   in_column = '0;
    logic [ROW_W-1:0]   in_row = '0;
    logic [LAYER_W-1:0] in_layer = '0;
    logic               in_clear = 1'b0;
    logic               in_VRAM_available = 1'b0;
    logic               out_write_available;
    logic               out_write;
    logic [ADDR_W-1:0]  out_addr;
    logic [PX_W-1:0]    out_px_data;
    logic [LAYER_W-1:0] out_layer;
    logic               out_busy;
    logic               out_clear_done;

    int checks = 0;
    int errors = 0;

    command_decoder_fifo #(
        .COL_W(COL_W), .ROW_W(ROW_W), .PX_W(PX_W), .LAYERS(LAYERS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_write(in_write), .in_px_data(in_px_data), .in_column(in_column),
        .in_row(in_row), .in_layer(in_layer), .in_clear(in_clear),
        .in_VRAM_available(in_VRAM_available),
        .out_write_available(out_write_available), .out_write(out_write),
        .out_addr(out_addr), .out_px_data(out_px_data), .out_layer(out_layer),
        .out_busy(out_busy), .out_clear_done(out_clear_done)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic w, input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row,
                         input logic [PX_W-1:0] px, input logic [LAYER_W-1:0] lay,
                         input logic clr, input logic vram);
        in_write          = w;
        in_column         = col;
        in_row            = row;
        in_px_data        = px;
        in_layer          = lay;
        in_clear          = clr;
        in_VRAM_available = vram;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wr_t mk(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                               input logic [PX_W-1:0] px, input logic [LAYER_W-1:0] lay);
        wr_t e;
        e.addr  = {row, col};
        e.px    = px;
        e.layer = lay;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 6'd1, 6'd1, 8'h12, 2'd0, 1'b0, 1'b1);
        repeat (2) tick();
        checks++; if (out_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_write: got %b expected 0", out_write); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", out_busy); end
        checks++; if (out_clear_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_clear_done: got %b expected 0", out_clear_done); end
        checks++; if (out_addr !== '0 || out_px_data !== '0 || out_layer !== '0) begin errors++; $display("[TB] FAIL reset_fields: got %h/%h/%h expected 0/0/0", out_addr, out_px_data, out_layer); end
        checks++; if (out_write_available !== 1'b0) begin errors++; $display("[TB] FAIL reset_available_low: got %b expected 0", out_write_available); end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checks++; if (out_write_available !== 1'b1) begin errors++; $display("[TB] FAIL reset_available_release: got %b expected 1", out_write_available); end
        tick();
        checks++; if (out_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_empty: got %b expected 0", out_write); end
    endtask

    task automatic test_single_write();
        drive(1'b1, 6'd13, 6'd32, 8'hF2, 2'd0, 1'b0, 1'b1);
        tick();
        checks++; if (out_write !== 1'b0) begin errors++; $display("[TB] FAIL single_early: got %b expected 0", out_write); end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        tick();
        checks++; if (out_write !== 1'b1 || out_addr !== 12'h80D || out_px_data !== 8'hF2 || out_layer !== 2'd0) begin
            errors++; $display("[TB] FAIL single_write: got w=%b a=%h p=%h l=%0d expected w=1 a=80d p=f2 l=0", out_write, out_addr, out_px_data, out_layer);
        end
        tick();
        checks++; if (out_write !== 1'b0 || out_addr !== 12'h80D) begin errors++; $display("[TB] FAIL single_hold: got w=%b a=%h expected w=0 a=80d", out_write, out_addr); end
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 5; i++) begin
            checks++; if (out_write_available !== (i <= 4)) begin errors++; $display("[TB] FAIL bp_available_%0d: got %b expected %b", i, out_write_available, (i <= 4)); end
            drive(1'b1, 6'(i), 6'd32, 8'(i * 17), 2'd0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (out_write !== 1'b1 || out_addr !== 12'(2048 + k) || out_px_data !== 8'(k * 17)) begin
                errors++; $display("[TB] FAIL bp_drain_%0d: got w=%b a=%h p=%h expected w=1 a=%h p=%h", k, out_write, out_addr, out_px_data, 12'(2048 + k), 8'(k * 17));
            end
            if (k == 1) begin
                checks++; if (out_write_available !== 1'b1) begin errors++; $display("[TB] FAIL bp_available_after_pop: got %b expected 1", out_write_available); end
            end
        end
        tick();
        checks++; if (out_write !== 1'b0) begin errors++; $display("[TB] FAIL bp_fifth_lost: got %b expected 0", out_write); end
    endtask

    task automatic test_full_pushpop();
        wr_t exp_q[$];
        wr_t e;
        logic [PX_W-1:0]    px;
        logic [LAYER_W-1:0] lay;
        for (int i = 0; i < 3; i++) begin
            px  = 8'($urandom);
            lay = 2'($urandom_range(0, LAYERS - 1));
            drive(1'b1, 6'(10 + i), 6'd3, px, lay, 1'b0, 1'b0);
            exp_q.push_back(mk(6'd3, 6'(10 + i), px, lay));
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_write_available !== 1'b1) begin errors++; $display("[TB] FAIL pp_available_%0d: got %b expected 1", i, out_write_available); end
            px  = 8'($urandom);
            lay = 2'($urandom_range(0, LAYERS - 1));
            drive(1'b1, 6'(20 + i), 6'd7, px, lay, 1'b0, 1'b1);
            exp_q.push_back(mk(6'd7, 6'(20 + i), px, lay));
            tick();
            e = exp_q.pop_front();
            checks++; if (out_write !== 1'b1 || out_addr !== e.addr || out_px_data !== e.px || out_layer !== e.layer) begin
                errors++; $display("[TB] FAIL pp_write_%0d: got w=%b a=%h p=%h l=%0d expected w=1 a=%h p=%h l=%0d", i, out_write, out_addr, out_px_data, out_layer, e.addr, e.px, e.layer);
            end
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++; if (out_write !== 1'b1 || out_addr !== e.addr || out_px_data !== e.px || out_layer !== e.layer) begin
                errors++; $display("[TB] FAIL pp_tail_%0d: got w=%b a=%h p=%h expected w=1 a=%h p=%h", i, out_write, out_addr, out_px_data, e.addr, e.px);
            end
        end
        tick();
        checks++; if (out_write !== 1'b0) begin errors++; $display("[TB] FAIL pp_empty: got %b expected 0", out_write); end
    endtask

    task automatic test_invalid_layer();
        drive(1'b1, 6'd5, 6'd5, 8'h99, 2'd3, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_write !== 1'b0) begin errors++; $display("[TB] FAIL drop_layer_%0d: got %b expected 0", i, out_write); end
        end
        drive(1'b0, '0, '0, 8'h77, 2'd3, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        checks++; if (out_busy !== 1'b1) begin errors++; $display("[TB] FAIL badclr_busy: got %b expected 1", out_busy); end
        tick();
        checks++; if (out_clear_done !== 1'b1 || out_write !== 1'b0 || out_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL badclr_done: got done=%b w=%b busy=%b expected 1/0/0", out_clear_done, out_write, out_busy);
        end
        tick();
        checks++; if (out_clear_done !== 1'b0) begin errors++; $display("[TB] FAIL badclr_pulse: got %b expected 0", out_clear_done); end
    endtask

    task automatic test_clear();
        drive(1'b0, '0, '0, 8'hAA, 2'd2, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        checks++; if (out_busy !== 1'b1) begin errors++; $display("[TB] FAIL clr_busy_start: got %b expected 1", out_busy); end
        for (int i = 0; i < CLEAR_LEN; i++) begin
            tick();
            checks++; if (out_write !== 1'b1 || out_addr !== 12'(i) || out_px_data !== 8'hAA || out_layer !== 2'd2) begin
                errors++; $display("[TB] FAIL clr_write_%0d: got w=%b a=%h p=%h l=%0d expected w=1 a=%h p=aa l=2", i, out_write, out_addr, out_px_data, out_layer, 12'(i));
            end
            checks++; if (out_clear_done !== (i == CLEAR_LEN - 1)) begin errors++; $display("[TB] FAIL clr_done_%0d: got %b expected %b", i, out_clear_done, (i == CLEAR_LEN - 1)); end
            checks++; if (out_busy !== (i != CLEAR_LEN - 1)) begin errors++; $display("[TB] FAIL clr_busy_%0d: got %b expected %b", i, out_busy, (i != CLEAR_LEN - 1)); end
        end
        tick();
        checks++; if (out_write !== 1'b0 || out_clear_done !== 1'b0) begin errors++; $display("[TB] FAIL clr_after: got w=%b done=%b expected 0/0", out_write, out_clear_done); end
    endtask

    task automatic test_clear_pending();
        wr_t pend[2];
        wr_t e;
        int idx;
        int cyc;
        logic v;
        pend[0] = mk(6'd5, 6'd1, 8'h21, 2'd0);
        pend[1] = mk(6'd5, 6'd2, 8'h22, 2'd1);
        drive(1'b1, 6'd1, 6'd5, 8'h21, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'd2, 6'd5, 8'h22, 2'd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 8'h3C, 2'd1, 1'b1, 1'b0);
        tick();
        idx = 0;
        cyc = 0;
        while (idx < 2 + CLEAR_LEN && cyc < 20000) begin
            v = 1'($urandom);
            drive(1'b1, 6'($urandom), 6'($urandom), 8'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), v);
            tick();
            cyc++;
            if (out_write === 1'b1) begin
                e = (idx < 2) ? pend[idx] : mk(6'((idx - 2) >> COL_W), 6'(idx - 2), 8'h3C, 2'd1);
                checks++; if (!v || out_addr !== e.addr || out_px_data !== e.px || out_layer !== e.layer) begin
                    errors++; $display("[TB] FAIL pend_write_%0d: got vram=%b a=%h p=%h l=%0d expected vram=1 a=%h p=%h l=%0d", idx, v, out_addr, out_px_data, out_layer, e.addr, e.px, e.layer);
                end
                checks++; if (out_clear_done !== (idx == 1 + CLEAR_LEN)) begin errors++; $display("[TB] FAIL pend_done_%0d: got %b expected %b", idx, out_clear_done, (idx == 1 + CLEAR_LEN)); end
                idx++;
            end else if (out_clear_done !== 1'b0) begin
                checks++; errors++; $display("[TB] FAIL pend_stray_done: got 1 expected 0 at write %0d", idx);
            end
            if (out_busy !== (idx < 2 + CLEAR_LEN)) begin
                checks++; errors++; $display("[TB] FAIL pend_busy_%0d: got %b expected %b", idx, out_busy, (idx < 2 + CLEAR_LEN));
            end
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        checks++; if (idx != 2 + CLEAR_LEN) begin errors++; $display("[TB] FAIL pend_timeout: got %0d writes expected %0d", idx, 2 + CLEAR_LEN); end
        repeat (2) tick();
        checks++; if (out_write !== 1'b0) begin errors++; $display("[TB] FAIL pend_ignored_writes: got %b expected 0", out_write); end
    endtask

    task automatic test_reset_mid_clear();
        drive(1'b0, '0, '0, 8'h55, 2'd0, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        repeat (8) tick();
        checks++; if (out_write !== 1'b1 || out_addr !== 12'd7) begin errors++; $display("[TB] FAIL rmc_at7: got w=%b a=%h expected w=1 a=007", out_write, out_addr); end
        rst = 1'b0;
        tick();
        checks++; if (out_write !== 1'b0 || out_busy !== 1'b0 || out_clear_done !== 1'b0) begin
            errors++; $display("[TB] FAIL rmc_reset: got w=%b busy=%b done=%b expected 0/0/0", out_write, out_busy, out_clear_done);
        end
        checks++; if (out_write_available !== 1'b0) begin errors++; $display("[TB] FAIL rmc_available_low: got %b expected 0", out_write_available); end
        rst = 1'b1;
        #1;
        checks++; if (out_write_available !== 1'b1) begin errors++; $display("[TB] FAIL rmc_available: got %b expected 1", out_write_available); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_write !== 1'b0 || out_clear_done !== 1'b0) begin errors++; $display("[TB] FAIL rmc_quiet_%0d: got w=%b done=%b expected 0/0", i, out_write, out_clear_done); end
        end
    endtask

    task automatic test_random();
        wr_t mq[$];
        wr_t e;
        logic w;
        logic v;
        logic avail_exp;
        logic pop_exp;
        logic [COL_W-1:0]   col;
        logic [ROW_W-1:0]   row;
        logic [PX_W-1:0]    px;
        logic [LAYER_W-1:0] lay;
        int guard;
        for (int c = 0; c < 400; c++) begin
            w   = 1'($urandom);
            v   = ($urandom_range(0, 2) != 0);
            col = 6'($urandom);
            row = 6'($urandom);
            px  = 8'($urandom);
            lay = 2'($urandom);
            avail_exp = (mq.size() < DEPTH);
            checks++; if (out_write_available !== avail_exp) begin errors++; $display("[TB] FAIL rnd_available_%0d: got %b expected %b", c, out_write_available, avail_exp); end
            drive(w, col, row, px, lay, 1'b0, v);
            pop_exp = v && (mq.size() > 0);
            tick();
            checks++; if (out_write !== pop_exp) begin errors++; $display("[TB] FAIL rnd_strobe_%0d: got %b expected %b", c, out_write, pop_exp); end
            if (pop_exp) begin
                e = mq.pop_front();
                checks++; if (out_addr !== e.addr || out_px_data !== e.px || out_layer !== e.layer) begin
                    errors++; $display("[TB] FAIL rnd_data_%0d: got a=%h p=%h l=%0d expected a=%h p=%h l=%0d", c, out_addr, out_px_data, out_layer, e.addr, e.px, e.layer);
                end
            end
            if (w && avail_exp && lay < LAYERS) mq.push_back(mk(row, col, px, lay));
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        guard = 0;
        while (mq.size() > 0 && guard < 20) begin
            tick();
            guard++;
            e = mq.pop_front();
            checks++; if (out_write !== 1'b1 || out_addr !== e.addr || out_px_data !== e.px) begin
                errors++; $display("[TB] FAIL rnd_drain_%0d: got w=%b a=%h p=%h expected w=1 a=%h p=%h", guard, out_write, out_addr, out_px_data, e.addr, e.px);
            end
        end
        tick();
        checks++; if (out_write !== 1'b0) begin errors++; $display("[TB] FAIL rnd_final_empty: got %b expected 0", out_write); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_full_pushpop();
        test_invalid_layer();
        test_clear();
        test_clear_pending();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
